// File: rtl/bram_asym_stream.sv
// Asymmetric single-clock line buffer: narrow words stream in, wide lines are read by address.
// Optional feature macro: BRAM_ASYM_OUTREG_EN adds a second read output register stage.
module bram_asym_stream #(
  parameter  int A_WIDTH         = 32,
  parameter  int RATIO           = 2,
  parameter  int DEPTH_B         = 8,
  localparam int B_WIDTH         = A_WIDTH * RATIO,
  localparam int B_ADDRESS_WIDTH = $clog2(DEPTH_B)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [A_WIDTH-1:0]         a_data,
  input  logic                       b_en,
  input  logic                       b_consume,
  input  logic [B_ADDRESS_WIDTH-1:0] b_addr,
  output logic [B_WIDTH-1:0]         b_rdata,
  output logic                       b_rvalid,
  output logic [DEPTH_B-1:0]         line_full,
  output logic [B_ADDRESS_WIDTH:0]   full_count
);

  // A RATIO of 1 still gets a one-bit slot counter that simply stays at zero.
  localparam int SLOT_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [B_WIDTH-1:0]         mem [DEPTH_B];
  logic [B_ADDRESS_WIDTH-1:0] wr_line;
  logic [SLOT_WIDTH-1:0]      wr_slot;
  logic                       wr_fire;
  logic                       wr_last;
  logic                       rd_consume;
  logic [DEPTH_B-1:0]         set_mask;
  logic [DEPTH_B-1:0]         clr_mask;
  logic [B_WIDTH-1:0]         rd_data_q;
  logic                       rd_valid_q;

  assign a_ready    = ~line_full[wr_line];
  assign wr_fire    = a_valid && a_ready;
  assign wr_last    = (wr_slot == SLOT_WIDTH'(RATIO - 1));
  assign rd_consume = b_en && b_consume && line_full[b_addr];

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (wr_fire && wr_last) set_mask[wr_line] = 1'b1;
    if (rd_consume)         clr_mask[b_addr]  = 1'b1;
  end

  // Write pointer: {wr_line, wr_slot}, wrapping naturally since DEPTH_B is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_line <= '0;
      wr_slot <= '0;
    end else if (wr_fire) begin
      if (wr_last) begin
        wr_slot <= '0;
        wr_line <= wr_line + B_ADDRESS_WIDTH'(1);
      end else begin
        wr_slot <= wr_slot + SLOT_WIDTH'(1);
      end
    end
  end

  // Set and consume never hit the same line, so the count moves only when exactly one fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_full  <= '0;
      full_count <= '0;
    end else begin
      line_full <= (line_full | set_mask) & ~clr_mask;
      case ({|set_mask, rd_consume})
        2'b10:   full_count <= full_count + (B_ADDRESS_WIDTH+1)'(1);
        2'b01:   full_count <= full_count - (B_ADDRESS_WIDTH+1)'(1);
        default: full_count <= full_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset so it maps onto block RAM; only control state is cleared.
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) begin
      for (int k = 0; k < RATIO; k++) begin
        if (wr_slot == SLOT_WIDTH'(k)) mem[wr_line][k*A_WIDTH +: A_WIDTH] <= a_data;
      end
    end
  end

  // NOTE: non-blocking read of mem in the same edge as a write gives read-first (old) contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= b_en && line_full[b_addr];
      if (b_en) rd_data_q <= mem[b_addr];
    end
  end

`ifdef BRAM_ASYM_OUTREG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      b_rdata  <= '0;
      b_rvalid <= 1'b0;
    end else begin
      b_rdata  <= rd_data_q;
      b_rvalid <= rd_valid_q;
    end
  end
`else
  assign b_rdata  = rd_data_q;
  assign b_rvalid = rd_valid_q;
`endif

endmodule

// File: tb/tb_bram_asym_stream.sv
// Directed self-checking bench for bram_asym_stream (A_WIDTH=32, RATIO=2, DEPTH_B=8).
// Read latency follows BRAM_ASYM_OUTREG_EN when it is defined for the build.
module tb_bram_asym_stream;

`ifdef BRAM_ASYM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [31:0] a_data = '0;
  logic        b_en = 1'b0;
  logic        b_consume = 1'b0;
  logic [2:0]  b_addr = '0;
  logic [63:0] b_rdata;
  logic        b_rvalid;
  logic [7:0]  line_full;
  logic [3:0]  full_count;

  int n_cmp = 0;
  int n_err = 0;

  bram_asym_stream #(.A_WIDTH(32), .RATIO(2), .DEPTH_B(8)) dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_en(b_en), .b_consume(b_consume), .b_addr(b_addr), .b_rdata(b_rdata),
    .b_rvalid(b_rvalid), .line_full(line_full), .full_count(full_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; a_valid = 1'b0; b_en = 1'b0; b_consume = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] d);
    a_valid = 1'b1; a_data = d;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] addr, input logic consume);
    b_en = 1'b1; b_addr = addr; b_consume = consume;
    tick();
    b_en = 1'b0; b_consume = 1'b0;
    repeat (LAT - 1) tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b want 0", b_rvalid); end
    n_cmp++; if (b_rdata !== 64'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", b_rdata); end
    n_cmp++; if (line_full !== 8'h00) begin n_err++; $display("FAIL rst_line_full: got %h want 00", line_full); end
    n_cmp++; if (full_count !== 4'd0) begin n_err++; $display("FAIL rst_full_count: got %0d want 0", full_count); end
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL rst_a_ready: got %b want 1", a_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    write_word(32'h11111111);
    write_word(32'h22222222);
    n_cmp++; if (line_full !== 8'h01) begin n_err++; $display("FAIL basic_line_full: got %h want 01", line_full); end
    n_cmp++; if (full_count !== 4'd1) begin n_err++; $display("FAIL basic_full_count: got %0d want 1", full_count); end
    b_en = 1'b1; b_addr = 3'd0;
    tick();
    b_en = 1'b0;
`ifdef BRAM_ASYM_OUTREG_EN
    n_cmp++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL basic_stage1_rvalid: got %b want 0", b_rvalid); end
    tick();
`endif
    n_cmp++; if (b_rdata !== 64'h22222222_11111111) begin n_err++; $display("FAIL basic_rdata: got %h want 2222222211111111", b_rdata); end
    n_cmp++; if (b_rvalid !== 1'b1) begin n_err++; $display("FAIL basic_rvalid: got %b want 1", b_rvalid); end
    tick();
    tick();
    n_cmp++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL basic_idle_rvalid: got %b want 0", b_rvalid); end
    n_cmp++; if (b_rdata !== 64'h22222222_11111111) begin n_err++; $display("FAIL basic_hold_rdata: got %h want 2222222211111111", b_rdata); end
  endtask

  task automatic test_partial_read_first();
    do_reset();
    write_word(32'hAAAA0001);
    do_read(3'd0, 1'b1);
    // Upper word is left over from the previous test: memory survives reset.
    n_cmp++; if (b_rdata !== 64'h22222222_AAAA0001) begin n_err++; $display("FAIL partial_rdata: got %h want 22222222AAAA0001", b_rdata); end
    n_cmp++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL partial_rvalid: got %b want 0", b_rvalid); end
    n_cmp++; if (line_full !== 8'h00) begin n_err++; $display("FAIL partial_line_full: got %h want 00", line_full); end
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL partial_a_ready: got %b want 1", a_ready); end
    a_valid = 1'b1; a_data = 32'hBBBB0002;
    b_en = 1'b1; b_addr = 3'd0;
    tick();
    a_valid = 1'b0; b_en = 1'b0;
    repeat (LAT - 1) tick();
    n_cmp++; if (b_rdata !== 64'h22222222_AAAA0001) begin n_err++; $display("FAIL rdfirst_rdata: got %h want 22222222AAAA0001", b_rdata); end
    n_cmp++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL rdfirst_rvalid: got %b want 0", b_rvalid); end
    n_cmp++; if (line_full !== 8'h01) begin n_err++; $display("FAIL rdfirst_line_full: got %h want 01", line_full); end
    do_read(3'd0, 1'b0);
    n_cmp++; if (b_rdata !== 64'hBBBB0002_AAAA0001) begin n_err++; $display("FAIL rdfirst_new_rdata: got %h want BBBB0002AAAA0001", b_rdata); end
    n_cmp++; if (b_rvalid !== 1'b1) begin n_err++; $display("FAIL rdfirst_new_rvalid: got %b want 1", b_rvalid); end
  endtask

  task automatic test_full_wrap();
    int not_ready = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (a_ready !== 1'b1) not_ready++;
      write_word(32'h10000000 + i);
    end
    n_cmp++; if (not_ready !== 0) begin n_err++; $display("FAIL fill_stalls: got %0d want 0", not_ready); end
    n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL full_a_ready: got %b want 0", a_ready); end
    n_cmp++; if (full_count !== 4'd8) begin n_err++; $display("FAIL full_count8: got %0d want 8", full_count); end
    n_cmp++; if (line_full !== 8'hFF) begin n_err++; $display("FAIL full_line_full: got %h want FF", line_full); end
    a_valid = 1'b1; a_data = 32'hCAFE0017;
    tick(); tick(); tick();
    n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL held_a_ready: got %b want 0", a_ready); end
    n_cmp++; if (full_count !== 4'd8) begin n_err++; $display("FAIL held_full_count: got %0d want 8", full_count); end
    b_en = 1'b1; b_consume = 1'b1; b_addr = 3'd0;
    tick();
    b_en = 1'b0; b_consume = 1'b0;
    n_cmp++; if (line_full !== 8'hFE) begin n_err++; $display("FAIL consume_line_full: got %h want FE", line_full); end
    n_cmp++; if (full_count !== 4'd7) begin n_err++; $display("FAIL consume_full_count: got %0d want 7", full_count); end
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL consume_a_ready: got %b want 1", a_ready); end
    tick();
    a_valid = 1'b0;
    do_read(3'd0, 1'b0);
    n_cmp++; if (b_rdata !== 64'h10000001_CAFE0017) begin n_err++; $display("FAIL wrap_rdata: got %h want 10000001CAFE0017", b_rdata); end
    n_cmp++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL wrap_rvalid: got %b want 0", b_rvalid); end
    n_cmp++; if (full_count !== 4'd7) begin n_err++; $display("FAIL wrap_full_count: got %0d want 7", full_count); end
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL wrap_a_ready: got %b want 1", a_ready); end
  endtask

  task automatic test_set_and_consume();
    do_reset();
    for (int i = 0; i < 7; i++) write_word(32'h30000000 + i);
    n_cmp++; if (line_full !== 8'h07) begin n_err++; $display("FAIL sc_pre_line_full: got %h want 07", line_full); end
    a_valid = 1'b1; a_data = 32'h30000007;
    b_en = 1'b1; b_consume = 1'b1; b_addr = 3'd1;
    tick();
    a_valid = 1'b0; b_en = 1'b0; b_consume = 1'b0;
    n_cmp++; if (line_full !== 8'h0D) begin n_err++; $display("FAIL sc_line_full: got %h want 0D", line_full); end
    n_cmp++; if (full_count !== 4'd3) begin n_err++; $display("FAIL sc_full_count: got %0d want 3", full_count); end
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL sc_a_ready: got %b want 1", a_ready); end
    do_read(3'd3, 1'b0);
    n_cmp++; if (b_rdata !== 64'h30000007_30000006) begin n_err++; $display("FAIL sc_rdata: got %h want 3000000730000006", b_rdata); end
    n_cmp++; if (b_rvalid !== 1'b1) begin n_err++; $display("FAIL sc_rvalid: got %b want 1", b_rvalid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) write_word(32'h50000000 + i);
    n_cmp++; if (full_count !== 4'd3) begin n_err++; $display("FAIL mid_pre_full_count: got %0d want 3", full_count); end
    b_en = 1'b1; b_addr = 3'd0;
    tick();
    b_en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL mid_rvalid: got %b want 0", b_rvalid); end
    n_cmp++; if (line_full !== 8'h00) begin n_err++; $display("FAIL mid_line_full: got %h want 00", line_full); end
    n_cmp++; if (full_count !== 4'd0) begin n_err++; $display("FAIL mid_full_count: got %0d want 0", full_count); end
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL mid_a_ready: got %b want 1", a_ready); end
    tick();
    n_cmp++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL mid_late_rvalid: got %b want 0", b_rvalid); end
    write_word(32'hD0000000);
    write_word(32'hD0000001);
    n_cmp++; if (line_full !== 8'h01) begin n_err++; $display("FAIL mid_ptr_line_full: got %h want 01", line_full); end
    do_read(3'd0, 1'b0);
    n_cmp++; if (b_rdata !== 64'hD0000001_D0000000) begin n_err++; $display("FAIL mid_ptr_rdata: got %h want D0000001D0000000", b_rdata); end
    n_cmp++; if (b_rvalid !== 1'b1) begin n_err++; $display("FAIL mid_ptr_rvalid: got %b want 1", b_rvalid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_read_first();
    test_full_wrap();
    test_set_and_consume();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
